// File: rtl/tqvp_hx2003_pulse_receiver_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : tqvp_hx2003_pulse_receiver_pkg
// Shared symbol encoding, word format and capture state for the receiver.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package tqvp_hx2003_pulse_receiver_pkg;

  // Symbol codes are shared with the transmitter's program memory.
  localparam logic [1:0] SYM_LOW_A  = 2'd0;
  localparam logic [1:0] SYM_LOW_B  = 2'd1;
  localparam logic [1:0] SYM_HIGH_A = 2'd2;
  localparam logic [1:0] SYM_HIGH_B = 2'd3;

  localparam int SYMBOLS_PER_WORD = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic        last;
    logic [4:0]  count;
    logic [31:0] data;
  } rx_word_t;

  function automatic logic [1:0] make_symbol(input logic level, input logic is_long);
    if (level) begin
      return is_long ? SYM_HIGH_B : SYM_HIGH_A;
    end
    return is_long ? SYM_LOW_B : SYM_LOW_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_receiver_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : tqvp_hx2003_pulse_receiver_if
// Captured-word stream toward the register wrapper (valid/ready).
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface tqvp_hx2003_pulse_receiver_if;
  logic [31:0] word_data;
  logic [4:0]  word_count;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_data,
    output word_count,
    output word_last,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_count,
    input  word_last,
    input  word_valid,
    output word_ready
  );
endinterface
`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_receiver_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pulse_rx_word_fifo
// Synchronous word FIFO; a pop frees the slot for a same-cycle push when full.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module pulse_rx_word_fifo
  import tqvp_hx2003_pulse_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  input  logic     push,
  input  rx_word_t push_word,
  input  logic     pop,
  output rx_word_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];

  rx_word_t        mem_q [FIFO_DEPTH];
  rx_word_t        mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      // Storage is wiped as well so the head reads as zero while idle.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_word;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tqvp_hx2003_pulse_receiver
// Measures filtered high/low segments and packs short/long symbols into words.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tqvp_hx2003_pulse_receiver
  import tqvp_hx2003_pulse_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_in,
  input  logic       cfg_invert,
  input  logic [1:0] cfg_glitch,
  input  logic [3:0] cfg_prescaler,
  input  logic [7:0] cfg_threshold,
  input  logic [7:0] cfg_timeout,
  tqvp_hx2003_pulse_receiver_if.master word_if,
  output logic       overflow,
  output logic       busy
);

  rx_state_e   state_q, state_d;
  logic        filt_q, filt_d;
  logic        filt_prev_q, filt_prev_d;
  logic [1:0]  gcnt_q, gcnt_d;
  logic        seg_level_q, seg_level_d;
  logic [14:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  width_q, width_d;
  logic [31:0] pack_data_q, pack_data_d;
  logic [4:0]  pack_cnt_q, pack_cnt_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;

  logic        lvl;
  logic [14:0] tick_mask;
  logic        tick;
  logic        edge_seen;
  logic [7:0]  width_inc;
  logic        is_long;
  logic [1:0]  sym;
  logic        timeout_hit;
  logic [31:0] packed_word;
  logic        push;
  rx_word_t    push_word;
  logic        pop;
  rx_word_t    fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  assign pop = !fifo_empty && word_if.word_ready;

  // Datapath terms; width_inc already includes this cycle's tick so a
  // segment reports floor(cycles / 2^prescaler).
  always_comb begin
    lvl         = rx_in ^ cfg_invert;
    tick_mask   = (15'd1 << cfg_prescaler) - 15'd1;
    edge_seen   = filt_q ^ filt_prev_q;
    tick        = (state_q == MEASURE) && (tick_cnt_q == tick_mask);
    width_inc   = (tick && (width_q != 8'hFF)) ? width_q + 8'd1 : width_q;
    is_long     = (width_inc >= cfg_threshold);
    sym         = make_symbol(seg_level_q, is_long);
    timeout_hit = tick && (cfg_timeout != 8'd0) && (width_inc == cfg_timeout) && !edge_seen;
    packed_word = pack_data_q;
    packed_word[{pack_cnt_q[3:0], 1'b0} +: 2] = sym;
  end

  always_comb begin
    state_d     = state_q;
    filt_d      = filt_q;
    filt_prev_d = filt_prev_q;
    gcnt_d      = gcnt_q;
    seg_level_d = seg_level_q;
    tick_cnt_d  = tick_cnt_q;
    width_d     = width_q;
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    push_word   = '0;

    if (!en) begin
      state_d     = IDLE;
      filt_d      = lvl;
      filt_prev_d = lvl;
      gcnt_d      = 2'd0;
      seg_level_d = 1'b0;
      tick_cnt_d  = '0;
      width_d     = 8'd0;
      pack_data_d = '0;
      pack_cnt_d  = 5'd0;
      overflow_d  = 1'b0;
    end else begin
      if (state_q == IDLE) begin
        filt_d      = lvl;
        filt_prev_d = lvl;
        gcnt_d      = 2'd0;
      end else begin
        filt_prev_d = filt_q;
        if (lvl == filt_q) begin
          gcnt_d = 2'd0;
        end else if (gcnt_q == cfg_glitch) begin
          filt_d = lvl;
          gcnt_d = 2'd0;
        end else begin
          gcnt_d = gcnt_q + 2'd1;
        end
      end

      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (edge_seen) begin
            state_d     = MEASURE;
            seg_level_d = filt_q;
            width_d     = 8'd0;
            tick_cnt_d  = '0;
          end
        end
        MEASURE: begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + 15'd1;
          width_d    = width_inc;
          if (edge_seen) begin
            seg_level_d = filt_q;
            width_d     = 8'd0;
            tick_cnt_d  = '0;
            if (pack_cnt_q == 5'(SYMBOLS_PER_WORD - 1)) begin
              push        = 1'b1;
              push_word   = {1'b0, 5'(SYMBOLS_PER_WORD), packed_word};
              pack_data_d = '0;
              pack_cnt_d  = 5'd0;
            end else begin
              pack_data_d = packed_word;
              pack_cnt_d  = pack_cnt_q + 5'd1;
            end
          end else if (timeout_hit) begin
            // The idle segment that ran into the timeout yields no symbol.
            state_d    = ARMED;
            width_d    = 8'd0;
            tick_cnt_d = '0;
            if (pack_cnt_q != 5'd0) begin
              push        = 1'b1;
              push_word   = {1'b1, pack_cnt_q, pack_data_q};
              pack_data_d = '0;
              pack_cnt_d  = 5'd0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (push && fifo_full && !pop) begin
        overflow_d = 1'b1;
      end
    end

    busy_d = (state_d == MEASURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      gcnt_q      <= 2'd0;
      seg_level_q <= 1'b0;
      tick_cnt_q  <= '0;
      width_q     <= 8'd0;
      pack_data_q <= '0;
      pack_cnt_q  <= 5'd0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      gcnt_q      <= gcnt_d;
      seg_level_q <= seg_level_d;
      tick_cnt_q  <= tick_cnt_d;
      width_q     <= width_d;
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  pulse_rx_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (!en),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_if.word_data  = fifo_head.data;
  assign word_if.word_count = fifo_head.count;
  assign word_if.word_last  = fifo_head.last;
  assign word_if.word_valid = !fifo_empty;
  assign overflow           = overflow_q;
  assign busy               = busy_q;

endmodule
`default_nettype wire
